// File: rtl/fifo_sched_pkg.sv
// Shared constants and helpers for the four-bank FIFO access scheduler.
package fifo_sched_pkg;

  localparam int NUM_BANKS = 4;
  localparam int BANK_ID_W = 2;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_e;

  function automatic logic [NUM_BANKS-1:0] onehot_bank(input logic [BANK_ID_W-1:0] id);
    onehot_bank     = '0;
    onehot_bank[id] = 1'b1;
  endfunction

endpackage

// File: rtl/fifo_bank_scheduler_rr2_arb.sv
// Two-requester arbiter for one bank and one operation; priority flop lives in the caller.
module rr2_arb (
  input  logic req0,
  input  logic req1,
  input  logic eligible,
  input  logic pri,
  output logic gnt0,
  output logic gnt1,
  output logic conflict
);

  // On contention pri picks the winner (0 -> req0, 1 -> req1); otherwise any eligible request wins.
  assign conflict = eligible & req0 & req1;
  assign gnt0     = eligible & req0 & ~(req1 & pri);
  assign gnt1     = eligible & req1 & ~(req0 & ~pri);

endmodule

// File: rtl/fifo_bank_scheduler.sv
// Grants M0/M1 write and read access to four FIFO banks, tracking occupancy per bank
// and resolving same-bank contention with independent round-robin priority per operation.
module fifo_bank_scheduler
  import fifo_sched_pkg::*;
#(
  parameter int BANK_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_req_M0,
  input  logic [BANK_ID_W-1:0] wr_bank_M0,
  input  logic                 wr_req_M1,
  input  logic [BANK_ID_W-1:0] wr_bank_M1,
  input  logic                 rd_req_M0,
  input  logic [BANK_ID_W-1:0] rd_bank_M0,
  input  logic                 rd_req_M1,
  input  logic [BANK_ID_W-1:0] rd_bank_M1,
  output logic                 wr_gnt_M0,
  output logic                 wr_gnt_M1,
  output logic                 rd_gnt_M0,
  output logic                 rd_gnt_M1,
  output logic                 rd_valid_M0,
  output logic                 rd_valid_M1,
  output logic [NUM_BANKS-1:0] bank_full,
  output logic [NUM_BANKS-1:0] bank_empty,
  output logic [7:0]           conflict_cnt
);

  localparam int CNT_W = $clog2(BANK_DEPTH + 1);

  logic [CNT_W-1:0]     count [NUM_BANKS];
  logic [NUM_BANKS-1:0] wr_sel0, wr_sel1, rd_sel0, rd_sel1;
  logic [NUM_BANKS-1:0] wr_elig, rd_elig;
  logic [NUM_BANKS-1:0] wr_g0, wr_g1, rd_g0, rd_g1;
  logic [NUM_BANKS-1:0] wr_conf, rd_conf;
  logic [NUM_BANKS-1:0] wr_pri, rd_pri;

  assign wr_sel0 = wr_req_M0 ? onehot_bank(wr_bank_M0) : '0;
  assign wr_sel1 = wr_req_M1 ? onehot_bank(wr_bank_M1) : '0;
  assign rd_sel0 = rd_req_M0 ? onehot_bank(rd_bank_M0) : '0;
  assign rd_sel1 = rd_req_M1 ? onehot_bank(rd_bank_M1) : '0;

  // Eligibility uses only the registered count; gating with rst kills all grants during reset.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign wr_elig[b]    = rst && (count[b] != CNT_W'(BANK_DEPTH));
    assign rd_elig[b]    = rst && (count[b] != '0);
    assign bank_full[b]  = (count[b] == CNT_W'(BANK_DEPTH));
    assign bank_empty[b] = (count[b] == '0);

    rr2_arb u_wr_arb (
      .req0     (wr_sel0[b]),
      .req1     (wr_sel1[b]),
      .eligible (wr_elig[b]),
      .pri      (wr_pri[b]),
      .gnt0     (wr_g0[b]),
      .gnt1     (wr_g1[b]),
      .conflict (wr_conf[b])
    );

    rr2_arb u_rd_arb (
      .req0     (rd_sel0[b]),
      .req1     (rd_sel1[b]),
      .eligible (rd_elig[b]),
      .pri      (rd_pri[b]),
      .gnt0     (rd_g0[b]),
      .gnt1     (rd_g1[b]),
      .conflict (rd_conf[b])
    );
  end

  assign wr_gnt_M0 = |wr_g0;
  assign wr_gnt_M1 = |wr_g1;
  assign rd_gnt_M0 = |rd_g0;
  assign rd_gnt_M1 = |rd_g1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        count[i] <= count[i] + CNT_W'(wr_g0[i] | wr_g1[i]) - CNT_W'(rd_g0[i] | rd_g1[i]);
      end
    end
  end

  // Priority flips only for banks that saw contention this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_pri <= '0;
      rd_pri <= '0;
    end else begin
      wr_pri <= wr_pri ^ wr_conf;
      rd_pri <= rd_pri ^ rd_conf;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_M0  <= 1'b0;
      rd_valid_M1  <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      rd_valid_M0 <= rd_gnt_M0;
      rd_valid_M1 <= rd_gnt_M1;
      if ((|{wr_conf, rd_conf}) && (conflict_cnt != 8'hFF)) begin
        conflict_cnt <= conflict_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_bank_scheduler.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized
// traffic compared every cycle against a queue-free occupancy/priority model.
module tb_fifo_bank_scheduler;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_req_M0, wr_req_M1, rd_req_M0, rd_req_M1;
  logic [1:0] wr_bank_M0, wr_bank_M1, rd_bank_M0, rd_bank_M1;
  logic       wr_gnt_M0, wr_gnt_M1, rd_gnt_M0, rd_gnt_M1;
  logic       rd_valid_M0, rd_valid_M1;
  logic [3:0] bank_full, bank_empty;
  logic [7:0] conflict_cnt;

  int checks = 0;
  int errors = 0;

  int m_cnt [4];
  bit m_wpri [4];
  bit m_rpri [4];
  int m_conf;
  bit m_rv0, m_rv1;

  always #5 clk = ~clk;

  fifo_bank_scheduler #(.BANK_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_req_M0    (wr_req_M0),
    .wr_bank_M0   (wr_bank_M0),
    .wr_req_M1    (wr_req_M1),
    .wr_bank_M1   (wr_bank_M1),
    .rd_req_M0    (rd_req_M0),
    .rd_bank_M0   (rd_bank_M0),
    .rd_req_M1    (rd_req_M1),
    .rd_bank_M1   (rd_bank_M1),
    .wr_gnt_M0    (wr_gnt_M0),
    .wr_gnt_M1    (wr_gnt_M1),
    .rd_gnt_M0    (rd_gnt_M0),
    .rd_gnt_M1    (rd_gnt_M1),
    .rd_valid_M0  (rd_valid_M0),
    .rd_valid_M1  (rd_valid_M1),
    .bank_full    (bank_full),
    .bank_empty   (bank_empty),
    .conflict_cnt (conflict_cnt)
  );

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i]  = 0;
      m_wpri[i] = 0;
      m_rpri[i] = 0;
    end
    m_conf = 0;
    m_rv0  = 0;
    m_rv1  = 0;
  endtask

  // Resolves one operation type from the model's occupancy and priority, toggling priority on contention.
  task automatic model_arb(input bit is_wr, input bit q0, input logic [1:0] b0,
                           input bit q1, input logic [1:0] b1,
                           output bit g0, output bit g1, output bit cont);
    bit e0, e1;
    e0   = is_wr ? (m_cnt[b0] < DEPTH) : (m_cnt[b0] > 0);
    e1   = is_wr ? (m_cnt[b1] < DEPTH) : (m_cnt[b1] > 0);
    cont = q0 && q1 && (b0 == b1) && e0;
    if (cont) begin
      g0 = is_wr ? !m_wpri[b0] : !m_rpri[b0];
      g1 = !g0;
      if (is_wr) m_wpri[b0] = !m_wpri[b0];
      else       m_rpri[b0] = !m_rpri[b0];
    end else begin
      g0 = q0 && e0;
      g1 = q1 && e1;
    end
  endtask

  task automatic applyStimulus(input bit w0, input logic [1:0] wb0, input bit w1, input logic [1:0] wb1,
                               input bit r0, input logic [1:0] rb0, input bit r1, input logic [1:0] rb1);
    bit ew0, ew1, wc, er0, er1, rc;
    logic [3:0] exp_full, exp_empty;
    @(negedge clk);
    wr_req_M0 = w0; wr_bank_M0 = wb0;
    wr_req_M1 = w1; wr_bank_M1 = wb1;
    rd_req_M0 = r0; rd_bank_M0 = rb0;
    rd_req_M1 = r1; rd_bank_M1 = rb1;
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_full[i]  = (m_cnt[i] == DEPTH);
      exp_empty[i] = (m_cnt[i] == 0);
    end
    model_arb(1'b1, w0, wb0, w1, wb1, ew0, ew1, wc);
    model_arb(1'b0, r0, rb0, r1, rb1, er0, er1, rc);
    checkOutput("wr_gnt_M0", wr_gnt_M0, ew0);
    checkOutput("wr_gnt_M1", wr_gnt_M1, ew1);
    checkOutput("rd_gnt_M0", rd_gnt_M0, er0);
    checkOutput("rd_gnt_M1", rd_gnt_M1, er1);
    checkOutput("rd_valid_M0", rd_valid_M0, m_rv0);
    checkOutput("rd_valid_M1", rd_valid_M1, m_rv1);
    checkOutput("bank_full", bank_full, exp_full);
    checkOutput("bank_empty", bank_empty, exp_empty);
    checkOutput("conflict_cnt", conflict_cnt, 8'(m_conf));
    m_cnt[wb0] += int'(ew0);
    m_cnt[wb1] += int'(ew1);
    m_cnt[rb0] -= int'(er0);
    m_cnt[rb1] -= int'(er1);
    m_rv0 = er0;
    m_rv1 = er1;
    if ((wc || rc) && m_conf < 255) m_conf++;
  endtask

  task automatic idle_step();
    applyStimulus(0, 2'd0, 0, 2'd0, 0, 2'd0, 0, 2'd0);
  endtask

  task automatic random_step(input int wp, input int rp);
    applyStimulus($urandom_range(99) < wp, 2'($urandom_range(3)),
                  $urandom_range(99) < wp, 2'($urandom_range(3)),
                  $urandom_range(99) < rp, 2'($urandom_range(3)),
                  $urandom_range(99) < rp, 2'($urandom_range(3)));
  endtask

  // Asserts reset in the middle of a cycle with requests pending and checks the immediate clear.
  task automatic reset_mid_traffic();
    @(negedge clk);
    wr_req_M0 = 1; wr_bank_M0 = 2'd1;
    wr_req_M1 = 1; wr_bank_M1 = 2'd2;
    rd_req_M0 = 1; rd_bank_M0 = 2'd3;
    rd_req_M1 = 1; rd_bank_M1 = 2'd0;
    #1;
    rst = 1'b0;
    #1;
    checkOutput("rst_wr_gnt_M0", wr_gnt_M0, 8'd0);
    checkOutput("rst_wr_gnt_M1", wr_gnt_M1, 8'd0);
    checkOutput("rst_rd_gnt_M0", rd_gnt_M0, 8'd0);
    checkOutput("rst_rd_gnt_M1", rd_gnt_M1, 8'd0);
    checkOutput("rst_rd_valid", {rd_valid_M1, rd_valid_M0}, 8'd0);
    checkOutput("rst_bank_empty", bank_empty, 8'hF);
    checkOutput("rst_bank_full", bank_full, 8'h0);
    checkOutput("rst_conflict_cnt", conflict_cnt, 8'h0);
    wr_req_M0 = 0; wr_req_M1 = 0; rd_req_M0 = 0; rd_req_M1 = 0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bit exp_m0_pattern [4];
    exp_m0_pattern = '{1, 0, 1, 0};
    rst = 1'b0;
    wr_req_M0 = 0; wr_req_M1 = 0; rd_req_M0 = 0; rd_req_M1 = 0;
    wr_bank_M0 = 0; wr_bank_M1 = 0; rd_bank_M0 = 0; rd_bank_M1 = 0;
    model_reset();
    #3;
    checkOutput("reset_bank_empty", bank_empty, 8'hF);
    checkOutput("reset_bank_full", bank_full, 8'h0);
    checkOutput("reset_conflict_cnt", conflict_cnt, 8'h0);
    checkOutput("reset_rd_valid", {rd_valid_M1, rd_valid_M0}, 8'h0);
    @(negedge clk);
    rst = 1'b1;

    // M0 writes bank2 three times, M1 reads it back three times.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 2'd2, 0, 2'd0, 0, 2'd0, 0, 2'd0);
      checkOutput("b2_wr_gnt", wr_gnt_M0, 8'd1);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 2'd0, 0, 2'd0, 0, 2'd0, 1, 2'd2);
      checkOutput("b2_rd_gnt", rd_gnt_M1, 8'd1);
      if (i == 0) checkOutput("b2_empty_after_writes", bank_empty, 8'hB);
    end
    idle_step();
    checkOutput("b2_rd_valid_M1", rd_valid_M1, 8'd1);
    checkOutput("b2_empty_after_reads", bank_empty, 8'hF);

    // Fill bank1, then a ninth write is refused while a read still goes through.
    for (int i = 0; i < 8; i++) applyStimulus(1, 2'd1, 0, 2'd0, 0, 2'd0, 0, 2'd0);
    applyStimulus(1, 2'd1, 0, 2'd0, 0, 2'd0, 0, 2'd0);
    checkOutput("b1_ninth_wr_gnt", wr_gnt_M0, 8'd0);
    checkOutput("b1_full", bank_full, 8'b0010);
    applyStimulus(1, 2'd1, 0, 2'd0, 0, 2'd0, 1, 2'd1);
    checkOutput("b1_full_rd_gnt", rd_gnt_M1, 8'd1);
    checkOutput("b1_full_wr_gnt", wr_gnt_M0, 8'd0);
    idle_step();
    checkOutput("b1_not_full_at_7", bank_full, 8'h0);
    for (int i = 0; i < 7; i++) applyStimulus(0, 2'd0, 0, 2'd0, 1, 2'd1, 0, 2'd0);
    idle_step();
    checkOutput("b1_drained", bank_empty, 8'hF);

    // Contended writes to bank0 alternate starting with M0.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 2'd0, 1, 2'd0, 0, 2'd0, 0, 2'd0);
      checkOutput("b0_rr_gnt_M0", wr_gnt_M0, 8'(exp_m0_pattern[i]));
      checkOutput("b0_rr_gnt_M1", wr_gnt_M1, 8'(!exp_m0_pattern[i]));
    end
    applyStimulus(1, 2'd0, 1, 2'd3, 0, 2'd0, 0, 2'd0);
    checkOutput("diff_bank_gnt", {wr_gnt_M1, wr_gnt_M0}, 8'b11);
    checkOutput("conflict_after_rr", conflict_cnt, 8'd4);
    idle_step();
    checkOutput("conflict_unchanged", conflict_cnt, 8'd4);
    checkOutput("empty_after_diff_bank", bank_empty, 8'b0110);

    // Reading an empty bank while it is being written is refused for that cycle only.
    applyStimulus(0, 2'd0, 1, 2'd2, 1, 2'd2, 0, 2'd0);
    checkOutput("empty_rd_gnt", rd_gnt_M0, 8'd0);
    checkOutput("empty_wr_gnt", wr_gnt_M1, 8'd1);
    applyStimulus(0, 2'd0, 0, 2'd0, 1, 2'd2, 0, 2'd0);
    checkOutput("next_rd_gnt", rd_gnt_M0, 8'd1);
    idle_step();
    checkOutput("b2_back_to_empty", bank_empty, 8'b0110);

    // Randomized traffic, a mid-traffic reset, then more traffic long enough to saturate conflict_cnt.
    for (int i = 0; i < 1500; i++) random_step(70, 30);
    reset_mid_traffic();
    for (int i = 0; i < 2500; i++) random_step(60, 60);
    for (int i = 0; i < 1000; i++) random_step(30, 70);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
